// File: rtl/dbus_uncached_bridge.sv
// Uncached data-bus to cache-bus bridge: turns one CPU data request into a single-beat
// bus transaction, one at a time, for MMIO and other uncached regions.

package dbus_uncached_bridge_pkg;

  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef logic [3:0] mlen_t;
  localparam mlen_t MLEN1 = 4'd0;

  typedef logic [1:0] axi_burst_t;
  localparam axi_burst_t AXI_BURST_FIXED = 2'b00;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

module dbus_uncached_bridge
  import dbus_uncached_bridge_pkg::*;
#(
  parameter bit MASK_READ = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [31:0] addr_q;
  msize_t      size_q;
  logic [7:0]  strobe_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;

  logic [63:0] byte_mask;
  logic [7:0]  span_end;
  logic [7:0]  span_start;
  logic        bus_done;

  // Bytes from the access offset up to offset+size are kept; the span is clipped at byte 7.
  always_comb begin
    byte_mask  = '0;
    span_start = {5'd0, addr_q[2:0]};
    span_end   = span_start + (8'd1 << size_q);
    for (int i = 0; i < 8; i++) begin
      if ((8'(i) >= span_start) && (8'(i) < span_end)) begin
        byte_mask[i*8 +: 8] = 8'hFF;
      end
    end
  end

  assign bus_done = cresp.ready && cresp.last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      addr_q   <= '0;
      size_q   <= MSIZE1;
      strobe_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq.valid) begin
            addr_q   <= dreq.addr;
            size_q   <= dreq.size;
            strobe_q <= dreq.strobe;
            wdata_q  <= dreq.data;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // A ready beat without last is not a legal single-beat reply, so it is dropped.
          if (bus_done) begin
            if (|strobe_q) begin
              rdata_q <= '0;
            end else if (MASK_READ) begin
              rdata_q <= cresp.data & byte_mask;
            end else begin
              rdata_q <= cresp.data;
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    creq  = '0;
    dresp = '0;
    if (state == BUSY) begin
      creq.valid    = 1'b1;
      creq.is_write = |strobe_q;
      creq.size     = size_q;
      creq.addr     = addr_q;
      creq.strobe   = strobe_q;
      creq.data     = wdata_q;
      creq.len      = MLEN1;
      creq.burst    = AXI_BURST_FIXED;
    end
    if (state == RESP) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = rdata_q;
    end
  end

endmodule

// File: tb/tb_dbus_uncached_bridge.sv
// Directed self-checking bench for dbus_uncached_bridge; a second instance with
// MASK_READ=0 shares the stimulus to cover the unmasked read path.

module tb_dbus_uncached_bridge;
  import dbus_uncached_bridge_pkg::*;

  logic       clk;
  logic       resetn;
  dbus_req_t  dreq;
  cbus_resp_t cresp;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  dbus_resp_t dresp_nm;
  cbus_req_t  creq_nm;

  int errors = 0;
  int checks = 0;

  dbus_uncached_bridge #(.MASK_READ(1'b1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .dreq   (dreq),
    .dresp  (dresp),
    .creq   (creq),
    .cresp  (cresp)
  );

  dbus_uncached_bridge #(.MASK_READ(1'b0)) dut_nomask (
    .clk    (clk),
    .resetn (resetn),
    .dreq   (dreq),
    .dresp  (dresp_nm),
    .creq   (creq_nm),
    .cresp  (cresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    dreq   = '0;
    cresp  = '0;
    step();
    step();
    checks++;
    if (creq !== '0 || creq_nm !== '0) begin
      errors++;
      $display("[TB] FAIL reset_creq: got %h / %h, want 0", creq, creq_nm);
    end
    checks++;
    if (dresp !== '0 || dresp_nm !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dresp: got %h / %h, want 0", dresp, dresp_nm);
    end
    resetn = 1'b1;
    step();
    checks++;
    if (creq.valid !== 1'b0 || dresp.data_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: creq.valid=%b data_ok=%b, want 0/0", creq.valid, dresp.data_ok);
    end
  endtask

  task automatic test_read8();
    cbus_req_t  exp_req;
    dbus_resp_t exp_resp;
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h1000_0000;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'h00;
    dreq.data   = 64'h0;
    step();
    dreq.valid = 1'b0;
    exp_req          = '0;
    exp_req.valid    = 1'b1;
    exp_req.is_write = 1'b0;
    exp_req.size     = MSIZE8;
    exp_req.addr     = 32'h1000_0000;
    exp_req.len      = MLEN1;
    exp_req.burst    = AXI_BURST_FIXED;
    checks++;
    if (creq !== exp_req) begin
      errors++;
      $display("[TB] FAIL read8_creq: got %h, want %h", creq, exp_req);
    end
    step();
    checks++;
    if (creq !== exp_req || dresp !== '0) begin
      errors++;
      $display("[TB] FAIL read8_wait: creq=%h dresp=%h, want creq=%h dresp=0", creq, dresp, exp_req);
    end
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = 64'h1122_3344_5566_7788;
    step();
    cresp = '0;
    exp_resp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h1122_3344_5566_7788};
    checks++;
    if (dresp !== exp_resp) begin
      errors++;
      $display("[TB] FAIL read8_resp: got %h, want %h", dresp, exp_resp);
    end
    checks++;
    if (creq.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read8_creq_drop: creq.valid=%b, want 0", creq.valid);
    end
    step();
    checks++;
    if (dresp !== '0) begin
      errors++;
      $display("[TB] FAIL read8_single_pulse: got %h, want 0", dresp);
    end
  endtask

  task automatic test_byte_mask();
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h1000_0005;
    dreq.size   = MSIZE1;
    dreq.strobe = 8'h00;
    dreq.data   = 64'h0;
    step();
    dreq.valid  = 1'b0;
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    cresp = '0;
    checks++;
    if (dresp.data_ok !== 1'b1 || dresp.data !== 64'h0000_FF00_0000_0000) begin
      errors++;
      $display("[TB] FAIL byte_mask: ok=%b data=%h, want 1 / 0000ff0000000000", dresp.data_ok, dresp.data);
    end
    checks++;
    if (dresp_nm.data_ok !== 1'b1 || dresp_nm.data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL byte_nomask: ok=%b data=%h, want 1 / ffffffffffffffff", dresp_nm.data_ok, dresp_nm.data);
    end
    step();
    // An 8-byte read at offset 6 keeps only bytes 6 and 7.
    dreq.valid = 1'b1;
    dreq.addr  = 32'h1000_0006;
    dreq.size  = MSIZE8;
    step();
    dreq.valid  = 1'b0;
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    cresp = '0;
    checks++;
    if (dresp.data !== 64'hFFFF_0000_0000_0000) begin
      errors++;
      $display("[TB] FAIL mask_truncate: got %h, want ffff000000000000", dresp.data);
    end
    step();
  endtask

  task automatic test_halfword_write();
    cbus_req_t exp_req;
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h1000_0002;
    dreq.size   = MSIZE2;
    dreq.strobe = 8'h0C;
    dreq.data   = 64'h0000_0000_ABCD_0000;
    step();
    dreq.valid = 1'b0;
    exp_req          = '0;
    exp_req.valid    = 1'b1;
    exp_req.is_write = 1'b1;
    exp_req.size     = MSIZE2;
    exp_req.addr     = 32'h1000_0002;
    exp_req.strobe   = 8'h0C;
    exp_req.data     = 64'h0000_0000_ABCD_0000;
    exp_req.len      = MLEN1;
    exp_req.burst    = AXI_BURST_FIXED;
    checks++;
    if (creq !== exp_req || creq_nm !== exp_req) begin
      errors++;
      $display("[TB] FAIL write_creq: got %h, want %h", creq, exp_req);
    end
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    cresp = '0;
    checks++;
    if (dresp.addr_ok !== 1'b1 || dresp.data_ok !== 1'b1 || dresp.data !== 64'h0 || dresp_nm.data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL write_resp: got %h / %h, want ok=1 data=0", dresp, dresp_nm);
    end
    step();
    checks++;
    if (dresp !== '0 || creq !== '0) begin
      errors++;
      $display("[TB] FAIL write_after: dresp=%h creq=%h, want 0/0", dresp, creq);
    end
  endtask

  task automatic test_stall();
    cbus_req_t exp_req;
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h1000_0010;
    dreq.size   = MSIZE4;
    dreq.strobe = 8'h00;
    dreq.data   = 64'h0;
    step();
    // Scramble the CPU request while the bus is busy; the bridge must ignore it.
    dreq.valid  = 1'b0;
    dreq.addr   = 32'hDEAD_BEE0;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'h1234_5678_9ABC_DEF0;
    exp_req       = '0;
    exp_req.valid = 1'b1;
    exp_req.size  = MSIZE4;
    exp_req.addr  = 32'h1000_0010;
    exp_req.len   = MLEN1;
    exp_req.burst = AXI_BURST_FIXED;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (creq !== exp_req || dresp.data_ok !== 1'b0 || dresp.addr_ok !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_cycle%0d: creq=%h ok=%b%b, want %h ok=00", c, creq, dresp.addr_ok, dresp.data_ok, exp_req);
      end
      step();
    end
    cresp.ready = 1'b1;
    cresp.last  = 1'b0;
    cresp.data  = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    cresp = '0;
    checks++;
    if (creq !== exp_req || dresp.data_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_nolast: creq=%h data_ok=%b, want %h / 0", creq, dresp.data_ok, exp_req);
    end
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = 64'h0123_4567_89AB_CDEF;
    step();
    cresp = '0;
    checks++;
    if (dresp.data_ok !== 1'b1 || dresp.addr_ok !== 1'b1 || dresp.data !== 64'h0000_0000_89AB_CDEF) begin
      errors++;
      $display("[TB] FAIL stall_resp: got %h, want ok=11 data=0000000089abcdef", dresp);
    end
    checks++;
    if (dresp_nm.data !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("[TB] FAIL stall_resp_nomask: got %h, want 0123456789abcdef", dresp_nm.data);
    end
    step();
    checks++;
    if (creq.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_no_reissue: creq.valid=%b, want 0", creq.valid);
    end
    dreq = '0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_valid;
    logic [6:0] exp_ok;
    logic [6:0] got_valid;
    logic [6:0] got_ok;
    int         pulses;
    exp_valid = 7'b0001001;
    exp_ok    = 7'b0010010;
    got_valid = '0;
    got_ok    = '0;
    pulses    = 0;
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h1000_0008;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'h00;
    dreq.data   = 64'h0;
    cresp.data  = 64'h55AA_55AA_0F0F_F0F0;
    for (int c = 0; c < 7; c++) begin
      step();
      got_valid[c] = creq.valid;
      got_ok[c]    = dresp.data_ok;
      if (dresp.data_ok === 1'b1) begin
        pulses++;
        checks++;
        if (dresp.addr_ok !== 1'b1 || dresp.data !== 64'h55AA_55AA_0F0F_F0F0) begin
          errors++;
          $display("[TB] FAIL b2b_resp_cycle%0d: got %h, want ok=11 data=55aa55aa0f0ff0f0", c, dresp);
        end
      end
      cresp.ready = creq.valid;
      cresp.last  = creq.valid;
      if (c == 3) dreq.valid = 1'b0;
    end
    cresp = '0;
    dreq  = '0;
    checks++;
    if (got_valid !== exp_valid) begin
      errors++;
      $display("[TB] FAIL b2b_creq_valid: got %b, want %b", got_valid, exp_valid);
    end
    checks++;
    if (got_ok !== exp_ok) begin
      errors++;
      $display("[TB] FAIL b2b_data_ok: got %b, want %b", got_ok, exp_ok);
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("[TB] FAIL b2b_pulses: got %0d, want 2", pulses);
    end
  endtask

  task automatic test_reset_mid_busy();
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h1000_0018;
    dreq.size   = MSIZE4;
    dreq.strobe = 8'h0F;
    dreq.data   = 64'h0000_0000_CAFE_BABE;
    step();
    dreq = '0;
    checks++;
    if (creq.valid !== 1'b1 || creq.is_write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_pre_busy: valid=%b is_write=%b, want 1/1", creq.valid, creq.is_write);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (creq !== '0 || dresp !== '0 || creq_nm !== '0 || dresp_nm !== '0) begin
      errors++;
      $display("[TB] FAIL rst_async: creq=%h dresp=%h, want 0/0", creq, dresp);
    end
    step();
    resetn      = 1'b1;
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h1000_0020;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'h00;
    dreq.data   = 64'h0;
    step();
    dreq.valid = 1'b0;
    checks++;
    if (creq.valid !== 1'b1 || creq.addr !== 32'h1000_0020 || creq.is_write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_reaccept: valid=%b addr=%h is_write=%b, want 1/10000020/0", creq.valid, creq.addr, creq.is_write);
    end
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = 64'hCAFE_F00D_1234_5678;
    step();
    cresp = '0;
    checks++;
    if (dresp.data_ok !== 1'b1 || dresp.data !== 64'hCAFE_F00D_1234_5678) begin
      errors++;
      $display("[TB] FAIL rst_resp: ok=%b data=%h, want 1 / cafef00d12345678", dresp.data_ok, dresp.data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_read8();
    test_byte_mask();
    test_halfword_write();
    test_stall();
    test_back_to_back();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbus_uncached_bridge.md
# dbus_uncached_bridge

Converts one data-bus request (`dbus_req_t` / `dbus_resp_t`) into a single-beat cache-bus transaction (`cbus_req_t` / `cbus_resp_t`) for uncached address regions such as MMIO. It sits between the memory stage's uncached path and the cache-bus arbiter, alongside the data cache. It runs one transaction at a time and registers its request and response sides.

## Interface
- `MASK_READ`, default 1: when 1, read bytes outside the accessed size are forced to zero in `dresp.data`.
- `clk` in, 1 bit: the single clock; all state changes on its rising edge.
- `resetn` in, 1 bit: asynchronous, active-low reset.
- `dreq` in, `dbus_req_t`: CPU-side request (`valid`, `addr`, `size`, `strobe`, `data`).
- `dresp` out, `dbus_resp_t`: CPU-side response (`addr_ok`, `data_ok`, `data`).
- `creq` out, `cbus_req_t`: bus-side request toward the arbiter.
- `cresp` in, `cbus_resp_t`: bus-side response (`ready`, `last`, `data`).

## Operation
- States: IDLE, BUSY, RESP. Reset enters IDLE.
- IDLE
  - When `dreq.valid`=1, latch `addr`, `size`, `strobe` and `data`, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY drives `creq` from the latched fields:
  - `valid`=1.
  - `is_write` = |strobe.
  - `size` and `addr` passed through; `addr` is not realigned.
  - `strobe` and `data` passed through unchanged.
  - `len`=MLEN1, `burst`=AXI_BURST_FIXED.
- BUSY exit
  - On `cresp.ready`=1 && `cresp.last`=1, latch `cresp.data` and go to RESP.
  - `cresp.ready`=1 with `last`=0 is a protocol violation. Stay in BUSY and ignore the data.
- RESP
  - Drive `dresp.addr_ok`=1 and `dresp.data_ok`=1 with `dresp.data` set to the latched word, then go to IDLE.
  - For writes, `dresp.data`=0.
- Read masking (`MASK_READ`=1)
  - Let `off` = addr[2:0] and `n` = 1 << size bytes.
  - Byte `i` of `dresp.data` is kept when `off` <= i < `off`+n, otherwise zeroed.
  - A span running past byte 7 is truncated at byte 7; no wrap into byte 0.
  - With `MASK_READ`=0, all 64 bits pass through.
- `dreq` is sampled only in IDLE.
  - Changes or deassertion of `dreq` during BUSY or RESP are ignored.
  - The response pulse is still issued.
- In every state other than the one named above, the outputs are 0:
  - `creq` is all-zero outside BUSY.
  - `dresp` is all-zero outside RESP.

## Timing
- Reset value of every output is 0: all fields of `creq` and `dresp`.
- Reset is asynchronous. Asserting it mid-transaction returns the block to IDLE at once and drops `creq.valid`. The downstream bus must be reset together with the bridge.
- Accept in cycle T (IDLE, `dreq.valid`=1).
  - `creq.valid`=1 from T+1.
  - It is held stable until the cycle in which `ready`&&`last` is sampled.
- If `ready`&&`last` is sampled at cycle T+k (k>=1):
  - `dresp.addr_ok` and `dresp.data_ok` are high for exactly cycle T+k+1.
  - `creq.valid`=0 in that cycle.
- Minimum request-to-response latency is 2 cycles after acceptance.
- A held `dreq.valid` starts a new request at T+k+2. Back-to-back throughput is therefore one request per k+2 cycles.
- `addr_ok` and `data_ok` are never asserted separately.
- The bridge never issues a second `creq` before the first completes.

## Test plan
- Read, 8 bytes.
  - Stimulus: `dreq` addr=0x1000_0000, size=MSIZE8, strobe=0. Bus answers `ready`=`last`=1 two cycles after `creq.valid` with data 0x1122334455667788.
  - Required response: `creq` has is_write=0, len=MLEN1, burst=FIXED. One pulse with `addr_ok`=`data_ok`=1 and data=0x1122334455667788.
- Byte read with masking.
  - Stimulus: addr=0x1000_0005, size=MSIZE1. Bus returns 0xFFFFFFFFFFFFFFFF.
  - Required response: `dresp.data`=0x0000FF0000000000.
  - With `MASK_READ`=0, the same stimulus gives 0xFFFFFFFFFFFFFFFF.
- Halfword write.
  - Stimulus: addr=0x1000_0002, size=MSIZE2, strobe=0x0C, data=0x00000000ABCD0000.
  - Required response: `creq` has is_write=1, strobe=0x0C and the same data. `dresp.data`=0 in the single-cycle RESP pulse.
- Bus stall and unstable `dreq`.
  - Stimulus: hold `cresp.ready`=0 for 10 cycles, then insert one `ready`=1/`last`=0 beat. Deassert `dreq.valid` during BUSY.
  - Required response: `creq` stays stable throughout. The response appears only one cycle after `ready`&&`last`.
- Back-to-back requests.
  - Stimulus: keep `dreq.valid`=1 for two consecutive requests.
  - Required response: `creq.valid` is low for exactly one RESP cycle plus one IDLE cycle between them. Exactly two response pulses.
- Reset mid-BUSY.
  - Stimulus: drop `resetn` asynchronously between clock edges while in BUSY.
  - Required response: all outputs are 0 immediately. After release, the next `dreq.valid` is accepted normally.
